de2_115_sd_card_nios_key_in: RTL and testbench
==============================================

DE2_115_SD_CARD_NIOS_KEY_IN -- requirements
Module: de2_115_sd_card_nios_key_in

Interface
REQ-001 Parameter WIDTH, default 4: number of input bits, 1..32.
REQ-002 Parameter DB_CYCLES, default 4: debounce length in clk cycles; 0 disables debounce.
REQ-003 Parameter EDGE_TYPE, default 0: captured edge; 0 falling, 1 rising, 2 any.
REQ-004 Parameter IDLE_LEVEL, default 1: reset value of every internal input-state bit (1 = active-low keys).
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe; valid only with chipselect.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous external inputs.
REQ-012 readdata  output  32  read data, combinational from address, zero latency, zero wait states.
REQ-013 irq  output  1  level interrupt request, active-high.

Function
REQ-014 Register map: 0 data (RO, debounced inputs); 1 reserved (reads 0); 2 irq_mask (RW, WIDTH bits); 3 edge_capture (read; write-1-to-clear).
REQ-015 Write occurs in a cycle with chipselect=1 and write_n=0; writes to addresses 0 and 1 are ignored.
REQ-016 readdata = selected register zero-extended to 32 bits; bits above WIDTH always 0; reads have no side effects.
REQ-017 in_port passes through a 2-flop synchronizer per bit before any other use.
REQ-018 Per bit, a counter of width clog2(DB_CYCLES+1) increments each cycle the synchronized bit differs from the debounced bit, and clears whenever they match.
REQ-019 Debounced bit takes the synchronized value and its counter clears in the cycle the mismatch has persisted DB_CYCLES consecutive cycles; a mismatch lasting fewer cycles leaves the debounced bit unchanged.
REQ-020 DB_CYCLES=0: debounced bit is the synchronized bit registered once more (one clk).
REQ-021 Net latency: debounced bit changes on the (2+DB_CYCLES)th rising clk edge after in_port changes and is held stable.
REQ-022 Edge detect compares debounced bit with its value one cycle earlier; edge_capture bit sets one cycle after the debounced bit changes in the EDGE_TYPE direction.
REQ-023 edge_capture bits are sticky until cleared by writing 1 to that bit at address 3; writing 0 leaves the bit unchanged.
REQ-024 Same-cycle set and clear on one edge_capture bit: set wins (bit reads 1).
REQ-025 irq = OR over bits of (edge_capture AND irq_mask), combinational from registers; unmasking an already-captured bit asserts irq immediately.
REQ-026 Masking a bit deasserts its irq contribution but does not clear edge_capture.

Reset
REQ-027 reset_n=0 immediately forces: synchronizer, debounced and previous-value bits to IDLE_LEVEL; counters, irq_mask and edge_capture to 0; irq=0.
REQ-028 Reset mid-debounce discards the pending count; no edge is captured as a consequence of reset or its release while in_port sits at IDLE_LEVEL.

Verification (WIDTH=4, DB_CYCLES=4, EDGE_TYPE=0, IDLE_LEVEL=1)
REQ-029 Reset with in_port=4'hF, hold 20 cycles -> data reads 0xF, edge_capture 0x0, irq_mask 0x0, irq=0.
REQ-030 Drive in_port=4'hE and hold -> data reads 0xE from the 6th edge, edge_capture reads 0x1 from the 7th edge; irq stays 0 (mask 0).
REQ-031 Write irq_mask=0x1 with edge_capture=0x1 -> irq=1 the next cycle; write 0x1 to address 3 -> edge_capture 0x0, irq=0.
REQ-032 Pulse in_port[1] low for 3 cycles -> data stays 0xF/0xE as before, edge_capture[1] stays 0.
REQ-033 Clear-write to address 3 in the same cycle a new falling edge on bit 2 is captured -> edge_capture[2]=1.
REQ-034 Assert reset_n=0 at count 2 of a pending falling edge on bit 3 -> after release with in_port=4'hF: data 0xF, edge_capture 0x0, irq=0.

Source files
------------

// File: rtl/de2_115_sd_card_nios_key_in.sv
// Avalon-MM key/button input port: 2-flop synchronizer, per-bit debounce,
// edge capture with write-1-to-clear, and a maskable level interrupt.
module de2_115_sd_card_nios_key_in #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned EDGE_TYPE  = 0,
  parameter int unsigned IDLE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE = (IDLE_LEVEL != 0) ? '1 : '0;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] edge_bits;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  generate
    if (DB_CYCLES == 0) begin : g_no_db
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) db <= IDLE;
        else          db <= sync2;
      end
    end else begin : g_db
      localparam int unsigned CW = $clog2(DB_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
      logic [CW-1:0] cnt [WIDTH];

      // The counter reaches DB_CYCLES-1 after DB_CYCLES-1 mismatching
      // cycles; the next mismatching cycle is the DB_CYCLES-th and commits.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          db <= IDLE;
          for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2[i] == db[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
              db[i]  <= sync2[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_bits = prev & ~db;
      1:       edge_bits = ~prev & db;
      default: edge_bits = prev ^ db;
    endcase
  end

  assign wr_en    = chipselect && !write_n;
  assign clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge is ORed in after the clear, so set wins on a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= IDLE;
      mask    <= '0;
      capture <= '0;
    end else begin
      prev    <= db;
      capture <= (capture & ~clr_bits) | edge_bits;
      if (wr_en && address == 2'd2) mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = db;
      2'd2:    readdata[WIDTH-1:0] = mask;
      2'd3:    readdata[WIDTH-1:0] = capture;
      default: readdata = '0;
    endcase
  end

  assign irq = |(capture & mask);

endmodule

// File: tb/tb_de2_115_sd_card_nios_key_in.sv
// Bench for de2_115_sd_card_nios_key_in: directed register/timing cases plus
// random key activity checked every cycle against a window-based reference.
module tb_de2_115_sd_card_nios_key_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  de2_115_sd_card_nios_key_in #(
    .WIDTH(4), .DB_CYCLES(4), .EDGE_TYPE(0), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // Reference: a key bit follows the synchronized input once the last four
  // synchronized samples all disagree with the current debounced value.
  logic [3:0] m_s1, m_db, m_prev, m_mask, m_ec;
  logic [3:0] win [4];

  function automatic logic [3:0] flips();
    logic [3:0] f = 4'hF;
    for (int j = 0; j < 4; j++) f &= win[j] ^ m_db;
    return f;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_db};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, m_ec};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1   <= 4'hF;
      m_db   <= 4'hF;
      m_prev <= 4'hF;
      m_mask <= 4'h0;
      m_ec   <= 4'h0;
      for (int j = 0; j < 4; j++) win[j] <= 4'hF;
    end else begin
      m_s1   <= in_port;
      win[0] <= m_s1;
      for (int j = 1; j < 4; j++) win[j] <= win[j-1];
      m_db   <= m_db ^ flips();
      m_prev <= m_db;
      m_ec   <= (m_ec & ~((chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0))
                | (m_prev & ~m_db);
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[3:0];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_readdata", readdata, m_read(address));
      check("model_irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic look(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    @(negedge clk);
    check(name, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    chk_on  = 1'b1;

    // Reset state with keys idle
    tick(20);
    look("rst_data", 2'd0, 32'hF);
    tick(1);
    look("rst_capture", 2'd3, 32'h0);
    tick(1);
    look("rst_mask", 2'd2, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    tick(1);

    // Debounce latency: data changes on the 6th edge
    in_port = 4'hE;
    address = 2'd0;
    tick(5);
    look("data_edge5", 2'd0, 32'hF);
    tick(1);
    look("data_edge6", 2'd0, 32'hE);
    in_port = 4'hF;
    tick(1);
    do_reset();
    tick(20);

    // Capture latency: edge_capture sets on the 7th edge
    in_port = 4'hE;
    address = 2'd3;
    tick(6);
    look("cap_edge6", 2'd3, 32'h0);
    tick(1);
    look("cap_edge7", 2'd3, 32'h1);
    check("irq_masked", {31'd0, irq}, 32'd0);
    tick(2);

    // Unmask then clear
    wr(2'd2, 32'h1);
    @(negedge clk);
    check("irq_unmasked", {31'd0, irq}, 32'd1);
    tick(1);
    wr(2'd3, 32'h1);
    @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    tick(1);
    look("cap_cleared", 2'd3, 32'h0);
    tick(1);

    // Three-cycle glitch on bit 1 is rejected
    in_port = 4'hC;
    tick(3);
    in_port = 4'hE;
    tick(12);
    look("glitch_data", 2'd0, 32'hE);
    tick(1);
    look("glitch_cap", 2'd3, 32'h0);
    tick(1);

    // Clear write colliding with a new capture on bit 2: set wins
    in_port = 4'hA;
    tick(6);
    wr(2'd3, 32'h4);
    look("set_wins", 2'd3, 32'h4);
    tick(1);

    // Reset while bit 3 is two counts into a falling edge
    in_port = 4'h2;
    tick(4);
    reset_n = 1'b0;
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick(20);
    look("midreset_data", 2'd0, 32'hF);
    tick(1);
    look("midreset_cap", 2'd3, 32'h0);
    check("midreset_irq", {31'd0, irq}, 32'd0);
    tick(1);
    look("midreset_mask", 2'd2, 32'h0);
    tick(1);

    // Random key activity, register traffic and occasional resets
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) in_port = in_port ^ (4'h1 << $urandom_range(0, 3));
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        writedata  = $urandom;
        chipselect = 1'b1;
        write_n    = 1'($urandom_range(0, 1));
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
